// File: rtl/vga_sync_glyph_rom.sv
// 640x480@60 VGA raster counters with zero-latency sync/blank decode, plus a
// combinational 5x7 glyph ROM indexed by ASCII code.
module vga_sync_glyph_rom #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_BOTTOM  = 10,
  parameter int V_SYNC    = 2,
  parameter int V_TOP     = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  char_code,
  output logic [34:0] glyph,
  output logic        hsync,
  output logic        vsync,
  output logic        display_on,
  output logic [9:0]  hpos,
  output logic [9:0]  vpos
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_BOTTOM);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hpos <= '0;
      vpos <= '0;
    end else if (hpos == H_LAST) begin
      hpos <= '0;
      vpos <= (vpos == V_LAST) ? '0 : vpos + 10'd1;
    end else begin
      hpos <= hpos + 10'd1;
    end
  end

  assign hsync      = !((hpos >= HS_START) && (hpos <= HS_END));
  assign vsync      = !((vpos >= VS_START) && (vpos <= VS_END));
  assign display_on = (hpos < H_VIS) && (vpos < V_VIS);

  // Font rows are written top row first, leftmost pixel as the row's MSB, so
  // the table reads like the font sheet; the bit order is remapped below.
  logic [34:0] raw;

  always_comb begin
    raw = '0;
    case (char_code)
      7'h21: raw = {5'h04,5'h04,5'h04,5'h04,5'h00,5'h00,5'h04};
      7'h22: raw = {5'h0A,5'h0A,5'h0A,5'h00,5'h00,5'h00,5'h00};
      7'h23: raw = {5'h0A,5'h0A,5'h1F,5'h0A,5'h1F,5'h0A,5'h0A};
      7'h24: raw = {5'h04,5'h0F,5'h14,5'h0E,5'h05,5'h1E,5'h04};
      7'h25: raw = {5'h18,5'h19,5'h02,5'h04,5'h08,5'h13,5'h03};
      7'h26: raw = {5'h0C,5'h12,5'h14,5'h08,5'h15,5'h12,5'h0D};
      7'h27: raw = {5'h0C,5'h04,5'h08,5'h00,5'h00,5'h00,5'h00};
      7'h28: raw = {5'h02,5'h04,5'h08,5'h08,5'h08,5'h04,5'h02};
      7'h29: raw = {5'h08,5'h04,5'h02,5'h02,5'h02,5'h04,5'h08};
      7'h2A: raw = {5'h00,5'h04,5'h15,5'h0E,5'h15,5'h04,5'h00};
      7'h2B: raw = {5'h00,5'h04,5'h04,5'h1F,5'h04,5'h04,5'h00};
      7'h2C: raw = {5'h00,5'h00,5'h00,5'h00,5'h0C,5'h04,5'h08};
      7'h2D: raw = {5'h00,5'h00,5'h00,5'h1F,5'h00,5'h00,5'h00};
      7'h2E: raw = {5'h00,5'h00,5'h00,5'h00,5'h00,5'h0C,5'h0C};
      7'h2F: raw = {5'h00,5'h01,5'h02,5'h04,5'h08,5'h10,5'h00};
      7'h30: raw = {5'h0E,5'h11,5'h13,5'h15,5'h19,5'h11,5'h0E};
      7'h31: raw = {5'h04,5'h0C,5'h04,5'h04,5'h04,5'h04,5'h0E};
      7'h32: raw = {5'h0E,5'h11,5'h01,5'h02,5'h04,5'h08,5'h1F};
      7'h33: raw = {5'h1F,5'h02,5'h04,5'h02,5'h01,5'h11,5'h0E};
      7'h34: raw = {5'h02,5'h06,5'h0A,5'h12,5'h1F,5'h02,5'h02};
      7'h35: raw = {5'h1F,5'h10,5'h1E,5'h01,5'h01,5'h11,5'h0E};
      7'h36: raw = {5'h06,5'h08,5'h10,5'h1E,5'h11,5'h11,5'h0E};
      7'h37: raw = {5'h1F,5'h01,5'h02,5'h04,5'h08,5'h08,5'h08};
      7'h38: raw = {5'h0E,5'h11,5'h11,5'h0E,5'h11,5'h11,5'h0E};
      7'h39: raw = {5'h0E,5'h11,5'h11,5'h0F,5'h01,5'h02,5'h0C};
      7'h3A: raw = {5'h00,5'h0C,5'h0C,5'h00,5'h0C,5'h0C,5'h00};
      7'h3B: raw = {5'h00,5'h0C,5'h0C,5'h00,5'h0C,5'h04,5'h08};
      7'h3C: raw = {5'h02,5'h04,5'h08,5'h10,5'h08,5'h04,5'h02};
      7'h3D: raw = {5'h00,5'h00,5'h1F,5'h00,5'h1F,5'h00,5'h00};
      7'h3E: raw = {5'h08,5'h04,5'h02,5'h01,5'h02,5'h04,5'h08};
      7'h3F: raw = {5'h0E,5'h11,5'h01,5'h02,5'h04,5'h00,5'h04};
      7'h40: raw = {5'h0E,5'h11,5'h01,5'h0D,5'h15,5'h15,5'h0E};
      7'h41: raw = {5'h0E,5'h11,5'h11,5'h1F,5'h11,5'h11,5'h11};
      7'h42: raw = {5'h1E,5'h11,5'h11,5'h1E,5'h11,5'h11,5'h1E};
      7'h43: raw = {5'h0E,5'h11,5'h10,5'h10,5'h10,5'h11,5'h0E};
      7'h44: raw = {5'h1C,5'h12,5'h11,5'h11,5'h11,5'h12,5'h1C};
      7'h45: raw = {5'h1F,5'h10,5'h10,5'h1E,5'h10,5'h10,5'h1F};
      7'h46: raw = {5'h1F,5'h10,5'h10,5'h1E,5'h10,5'h10,5'h10};
      7'h47: raw = {5'h0E,5'h11,5'h10,5'h17,5'h11,5'h11,5'h0F};
      7'h48: raw = {5'h11,5'h11,5'h11,5'h1F,5'h11,5'h11,5'h11};
      7'h49: raw = {5'h0E,5'h04,5'h04,5'h04,5'h04,5'h04,5'h0E};
      7'h4A: raw = {5'h07,5'h02,5'h02,5'h02,5'h02,5'h12,5'h0C};
      7'h4B: raw = {5'h11,5'h12,5'h14,5'h18,5'h14,5'h12,5'h11};
      7'h4C: raw = {5'h10,5'h10,5'h10,5'h10,5'h10,5'h10,5'h1F};
      7'h4D: raw = {5'h11,5'h1B,5'h15,5'h15,5'h11,5'h11,5'h11};
      7'h4E: raw = {5'h11,5'h11,5'h19,5'h15,5'h13,5'h11,5'h11};
      7'h4F: raw = {5'h0E,5'h11,5'h11,5'h11,5'h11,5'h11,5'h0E};
      7'h50: raw = {5'h1E,5'h11,5'h11,5'h1E,5'h10,5'h10,5'h10};
      7'h51: raw = {5'h0E,5'h11,5'h11,5'h11,5'h15,5'h12,5'h0D};
      7'h52: raw = {5'h1E,5'h11,5'h11,5'h1E,5'h14,5'h12,5'h11};
      7'h53: raw = {5'h0F,5'h10,5'h10,5'h0E,5'h01,5'h01,5'h1E};
      7'h54: raw = {5'h1F,5'h04,5'h04,5'h04,5'h04,5'h04,5'h04};
      7'h55: raw = {5'h11,5'h11,5'h11,5'h11,5'h11,5'h11,5'h0E};
      7'h56: raw = {5'h11,5'h11,5'h11,5'h11,5'h11,5'h0A,5'h04};
      7'h57: raw = {5'h11,5'h11,5'h11,5'h15,5'h15,5'h15,5'h0A};
      7'h58: raw = {5'h11,5'h11,5'h0A,5'h04,5'h0A,5'h11,5'h11};
      7'h59: raw = {5'h11,5'h11,5'h11,5'h0A,5'h04,5'h04,5'h04};
      7'h5A: raw = {5'h1F,5'h01,5'h02,5'h04,5'h08,5'h10,5'h1F};
      7'h5B: raw = {5'h0E,5'h08,5'h08,5'h08,5'h08,5'h08,5'h0E};
      7'h5C: raw = {5'h11,5'h0A,5'h1F,5'h04,5'h1F,5'h04,5'h04};
      7'h5D: raw = {5'h0E,5'h02,5'h02,5'h02,5'h02,5'h02,5'h0E};
      7'h5E: raw = {5'h04,5'h0A,5'h11,5'h00,5'h00,5'h00,5'h00};
      7'h5F: raw = {5'h00,5'h00,5'h00,5'h00,5'h00,5'h00,5'h1F};
      7'h60: raw = {5'h08,5'h04,5'h02,5'h00,5'h00,5'h00,5'h00};
      7'h61: raw = {5'h00,5'h00,5'h0E,5'h01,5'h0F,5'h11,5'h0F};
      7'h62: raw = {5'h10,5'h10,5'h16,5'h19,5'h11,5'h11,5'h1E};
      7'h63: raw = {5'h00,5'h00,5'h0E,5'h10,5'h10,5'h11,5'h0E};
      7'h64: raw = {5'h01,5'h01,5'h0D,5'h13,5'h11,5'h11,5'h0F};
      7'h65: raw = {5'h00,5'h00,5'h0E,5'h11,5'h1F,5'h10,5'h0E};
      7'h66: raw = {5'h06,5'h09,5'h08,5'h1C,5'h08,5'h08,5'h08};
      7'h67: raw = {5'h00,5'h0F,5'h11,5'h11,5'h0F,5'h01,5'h0E};
      7'h68: raw = {5'h10,5'h10,5'h16,5'h19,5'h11,5'h11,5'h11};
      7'h69: raw = {5'h04,5'h00,5'h0C,5'h04,5'h04,5'h04,5'h0E};
      7'h6A: raw = {5'h02,5'h00,5'h06,5'h02,5'h02,5'h12,5'h0C};
      7'h6B: raw = {5'h10,5'h10,5'h12,5'h14,5'h18,5'h14,5'h12};
      7'h6C: raw = {5'h0C,5'h04,5'h04,5'h04,5'h04,5'h04,5'h0E};
      7'h6D: raw = {5'h00,5'h00,5'h1A,5'h15,5'h15,5'h11,5'h11};
      7'h6E: raw = {5'h00,5'h00,5'h16,5'h19,5'h11,5'h11,5'h11};
      7'h6F: raw = {5'h00,5'h00,5'h0E,5'h11,5'h11,5'h11,5'h0E};
      7'h70: raw = {5'h00,5'h00,5'h1E,5'h11,5'h1E,5'h10,5'h10};
      7'h71: raw = {5'h00,5'h00,5'h0D,5'h13,5'h0F,5'h01,5'h01};
      7'h72: raw = {5'h00,5'h00,5'h16,5'h19,5'h10,5'h10,5'h10};
      7'h73: raw = {5'h00,5'h00,5'h0E,5'h10,5'h0E,5'h01,5'h1E};
      7'h74: raw = {5'h08,5'h08,5'h1C,5'h08,5'h08,5'h09,5'h06};
      7'h75: raw = {5'h00,5'h00,5'h11,5'h11,5'h11,5'h13,5'h0D};
      7'h76: raw = {5'h00,5'h00,5'h11,5'h11,5'h11,5'h0A,5'h04};
      7'h77: raw = {5'h00,5'h00,5'h11,5'h11,5'h15,5'h15,5'h0A};
      7'h78: raw = {5'h00,5'h00,5'h11,5'h0A,5'h04,5'h0A,5'h11};
      7'h79: raw = {5'h00,5'h00,5'h11,5'h11,5'h0F,5'h01,5'h0E};
      7'h7A: raw = {5'h00,5'h00,5'h1F,5'h02,5'h04,5'h08,5'h1F};
      7'h7B: raw = {5'h02,5'h04,5'h04,5'h08,5'h04,5'h04,5'h02};
      7'h7C: raw = {5'h04,5'h04,5'h04,5'h04,5'h04,5'h04,5'h04};
      7'h7D: raw = {5'h08,5'h04,5'h04,5'h02,5'h04,5'h04,5'h08};
      7'h7E: raw = {5'h00,5'h04,5'h02,5'h1F,5'h02,5'h04,5'h00};
      default: raw = '0;
    endcase
  end

  // Row r lands at glyph[5r+4:5r] with column 0 (sheet MSB) in bit 5r.
  always_comb begin
    glyph = '0;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 5; c++)
        glyph[5*r+c] = raw[(6-r)*5 + (4-c)];
  end

endmodule

// File: tb/tb_vga_sync_glyph_rom.sv
// Bench: glyph vector table, cycle-by-cycle raster model on the full-size
// timing plus a shrunken-timing instance for frame wrap and vsync.
module tb_vga_sync_glyph_rom;
  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  char_code;
  logic [34:0] glyph, glyph_s;
  logic        hsync, vsync, display_on;
  logic        hsync_s, vsync_s, display_on_s;
  logic [9:0]  hpos, vpos, hpos_s, vpos_s;

  int checks = 0;
  int failures = 0;
  int fprints = 0;

  always #5 clk = ~clk;

  vga_sync_glyph_rom dut (
    .clk(clk), .reset(reset), .char_code(char_code), .glyph(glyph),
    .hsync(hsync), .vsync(vsync), .display_on(display_on),
    .hpos(hpos), .vpos(vpos)
  );

  // Small raster: 15 clocks/line (hsync low 10..12), 11 lines (vsync low 7..8).
  vga_sync_glyph_rom #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_BOTTOM(1), .V_SYNC(2), .V_TOP(2)
  ) dut_s (
    .clk(clk), .reset(reset), .char_code(char_code), .glyph(glyph_s),
    .hsync(hsync_s), .vsync(vsync_s), .display_on(display_on_s),
    .hpos(hpos_s), .vpos(vpos_s)
  );

  typedef struct {
    logic [6:0]  code;
    logic [34:0] exp;
  } gvec_t;

  gvec_t gv[12];

  // Rows given top-first, each as glyph bits [5r+4:5r] (bit0 = leftmost).
  function automatic logic [34:0] g7(input logic [4:0] r0, r1, r2, r3, r4, r5, r6);
    return {r6, r5, r4, r3, r2, r1, r0};
  endfunction

  task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference raster state
  int mh, mv, sh, sv;

  task automatic model_step();
    if (mh == 799) begin mh = 0; mv = (mv == 524) ? 0 : mv + 1; end
    else mh++;
    if (sh == 14) begin sh = 0; sv = (sv == 10) ? 0 : sv + 1; end
    else sh++;
  endtask

  task automatic cyc_check(input int cyc);
    logic [22:0] act, exp, act_s, exp_s;
    act = {hpos, vpos, hsync, vsync, display_on};
    exp = {10'(mh), 10'(mv), !(mh >= 656 && mh <= 751), !(mv >= 490 && mv <= 491),
           (mh < 640) && (mv < 480)};
    act_s = {hpos_s, vpos_s, hsync_s, vsync_s, display_on_s};
    exp_s = {10'(sh), 10'(sv), !(sh >= 10 && sh <= 12), !(sv >= 7 && sv <= 8),
             (sh < 8) && (sv < 6)};
    checks += 2;
    if (act !== exp) begin
      failures++;
      if (fprints < 10)
        $display("FAIL raster cyc%0d: got h=%0d v=%0d hs=%b vs=%b de=%b expected h=%0d v=%0d hs=%b vs=%b de=%b",
                 cyc, act[22:13], act[12:3], act[2], act[1], act[0], exp[22:13], exp[12:3], exp[2], exp[1], exp[0]);
      fprints++;
    end
    if (act_s !== exp_s) begin
      failures++;
      if (fprints < 10)
        $display("FAIL small_raster cyc%0d: got h=%0d v=%0d hs=%b vs=%b de=%b expected h=%0d v=%0d hs=%b vs=%b de=%b",
                 cyc, act_s[22:13], act_s[12:3], act_s[2], act_s[1], act_s[0], exp_s[22:13], exp_s[12:3], exp_s[2], exp_s[1], exp_s[0]);
      fprints++;
    end
  endtask

  int hs_low_line0, vs_low_small, wraps_small, v1_at;

  initial begin
    gv[0]  = '{7'h41, g7(5'h0E,5'h11,5'h11,5'h1F,5'h11,5'h11,5'h11)};
    gv[1]  = '{7'h20, 35'h0};
    gv[2]  = '{7'h00, 35'h0};
    gv[3]  = '{7'h1F, 35'h0};
    gv[4]  = '{7'h7F, 35'h0};
    gv[5]  = '{7'h7C, g7(5'h04,5'h04,5'h04,5'h04,5'h04,5'h04,5'h04)};
    gv[6]  = '{7'h4C, g7(5'h01,5'h01,5'h01,5'h01,5'h01,5'h01,5'h1F)};
    gv[7]  = '{7'h31, g7(5'h04,5'h06,5'h04,5'h04,5'h04,5'h04,5'h0E)};
    gv[8]  = '{7'h46, g7(5'h1F,5'h01,5'h01,5'h0F,5'h01,5'h01,5'h01)};
    gv[9]  = '{7'h54, g7(5'h1F,5'h04,5'h04,5'h04,5'h04,5'h04,5'h04)};
    gv[10] = '{7'h5F, g7(5'h00,5'h00,5'h00,5'h00,5'h00,5'h00,5'h1F)};
    gv[11] = '{7'h2D, g7(5'h00,5'h00,5'h00,5'h1F,5'h00,5'h00,5'h00)};

    reset = 1'b1;
    char_code = 7'h00;
    #1;
    chk("reset_hpos", 35'(hpos), 35'd0);
    chk("reset_vpos", 35'(vpos), 35'd0);
    chk("reset_syncs_de", 35'({hsync, vsync, display_on}), 35'b111);

    // Glyph ROM is independent of clock and reset.
    for (int i = 0; i < 12; i++) begin
      char_code = gv[i].code;
      #1;
      chk($sformatf("glyph_%0h", gv[i].code), glyph, gv[i].exp);
    end

    repeat (3) @(negedge clk);
    chk("reset_hold_hpos", 35'(hpos), 35'd0);
    reset = 1'b0;
    mh = 0; mv = 0; sh = 0; sv = 0;
    hs_low_line0 = 0; vs_low_small = 0; wraps_small = 0; v1_at = -1;

    for (int cyc = 1; cyc <= 1900; cyc++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      cyc_check(cyc);
      if (vpos == 10'd0 && !hsync) hs_low_line0++;
      if (vpos == 10'd1 && v1_at < 0) v1_at = cyc;
      if (!vsync_s) vs_low_small++;
      if (hpos_s == 10'd0 && vpos_s == 10'd0) wraps_small++;
    end

    chk("hsync_low_clocks_line0", 35'(hs_low_line0), 35'd96);
    chk("vpos_step_cycle", 35'(v1_at), 35'd800);
    // 1900 clocks = 126 full small frames' worth of lines + partial; vsync low
    // occupies 30 clocks per 165-clock frame: 11 full frames (1815) + 85 clocks.
    chk("small_vsync_low_clocks", 35'(vs_low_small), 35'd330);
    chk("small_frame_wraps", 35'(wraps_small), 35'd11);
    chk("pre_reset_pos", 35'({hpos, vpos}), 35'({10'd300, 10'd2}));

    // Asynchronous reset mid-line, away from any rising edge.
    #2 reset = 1'b1;
    #1;
    chk("async_rst_hpos", 35'(hpos), 35'd0);
    chk("async_rst_vpos", 35'(vpos), 35'd0);
    chk("async_rst_syncs", 35'({hsync, vsync, display_on}), 35'b111);
    @(negedge clk);
    reset = 1'b0;
    mh = 0; mv = 0; sh = 0; sv = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      cyc_check(2000 + cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
